aig_resp_misr: RTL and testbench

Downstream response compactor for the synthetic AIG mix blocks. It consumes the 64-bit `out` vectors produced by the combinational AIG stage through a valid/ready handshake. It folds a programmed number of vectors into a 64-bit multiple-input signature register (MISR) and presents the final signature with a done flag. This lets the bench and silicon compare one word instead of every vector.

---
 rtl/aig_mix_pkg.sv | 27 ++
 rtl/aig_misr_core.sv | 43 ++++
 rtl/aig_resp_misr.sv | 165 ++++++++++++++++
 tb/tb_aig_resp_misr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aig_mix_pkg.sv
// Shared types and constants for the AIG mix blocks and their response compactor.
// Holds the MISR step function so the signature core and the golden comparator agree.
package aig_mix_pkg;

    localparam int RESP_W = 64;

    localparam logic [RESP_W-1:0] MISR_POLY = 64'h8000_0000_0000_000D;
    localparam logic [RESP_W-1:0] MISR_SEED = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    // One MISR step: shift left, feed the tap parity into bit 0, fold in the new vector.
    function automatic logic [RESP_W-1:0] misr_step(
        input logic [RESP_W-1:0] sig,
        input logic [RESP_W-1:0] data,
        input logic [RESP_W-1:0] poly
    );
        logic fb;
        fb = ^(sig & poly);
        return {sig[RESP_W-2:0], fb} ^ data;
    endfunction

endpackage

// File: rtl/aig_misr_core.sv
// Signature register of the response compactor: seed load has priority over a step.
// Purely datapath; sequencing lives in aig_resp_misr.
module aig_misr_core
    import aig_mix_pkg::*;
#(
    parameter logic [RESP_W-1:0] POLY = MISR_POLY,
    parameter logic [RESP_W-1:0] SEED = MISR_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] data,
    output logic [RESP_W-1:0] sig
);

    logic [RESP_W-1:0] sig_r;
    logic [RESP_W-1:0] sig_nxt_s;

    // Next signature: seed, one step, or hold.
    always_comb begin
        sig_nxt_s = sig_r;
        if (load) begin
            sig_nxt_s = SEED;
        end else if (en) begin
            sig_nxt_s = misr_step(sig_r, data, POLY);
        end else begin
            sig_nxt_s = sig_r;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else begin
            sig_r <= sig_nxt_s;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/aig_resp_misr.sv
// Response compactor: folds num_vec handshaked AIG vectors into a 64-bit MISR signature.
// Optional macro AIG_MISR_GOLDEN_CMP_EN adds a golden-signature compare (match/mismatch).
module aig_resp_misr
    import aig_mix_pkg::*;
#(
    parameter int                DATA_W = RESP_W,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] POLY   = MISR_POLY,
    parameter logic [DATA_W-1:0] SEED   = MISR_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vec_count,
    output logic [DATA_W-1:0] sig_out
`ifdef AIG_MISR_GOLDEN_CMP_EN
    ,
    input  logic [DATA_W-1:0] golden_sig,
    output logic              match,
    output logic              mismatch
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    misr_state_e       state_r;
    misr_state_e       next_state_s;
    logic [CNT_W-1:0]  num_lat_r;
    logic [CNT_W-1:0]  vec_count_r;
    logic              busy_r;
    logic              done_r;
    logic              in_ready_s;
    logic              start_acc_s;
    logic              beat_s;
    logic              last_beat_s;
    logic [DATA_W-1:0] sig_s;

    assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign beat_s      = in_valid && in_ready_s;
    assign last_beat_s = beat_s && ((vec_count_r + CNT_ONE) == num_lat_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; a zero-length run skips RUN entirely.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    next_state_s = (num_vec == CNT_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_beat_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake decode from state only, so nothing combinational reaches back to in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_RUN:  in_ready_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Registered status flags track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_RUN);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    // Latched run length and accepted-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat_r   <= CNT_ZERO;
            vec_count_r <= CNT_ZERO;
        end else if (start_acc_s) begin
            num_lat_r   <= num_vec;
            vec_count_r <= CNT_ZERO;
        end else if (beat_s) begin
            vec_count_r <= vec_count_r + CNT_ONE;
        end else begin
            vec_count_r <= vec_count_r;
        end
    end

    aig_misr_core #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc_s),
        .en    (beat_s),
        .data  (in_data),
        .sig   (sig_s)
    );

`ifdef AIG_MISR_GOLDEN_CMP_EN
    logic              match_r;
    logic              mismatch_r;
    logic              done_entry_s;
    logic [DATA_W-1:0] final_sig_s;

    // The signature about to be registered on the DONE entry edge.
    assign done_entry_s = (next_state_s == ST_DONE) && (start_acc_s || (state_r == ST_RUN));
    assign final_sig_s  = start_acc_s ? SEED : misr_step(sig_s, in_data, POLY);

    // Golden compare captured on DONE entry, cleared by any accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_r    <= 1'b0;
            mismatch_r <= 1'b0;
        end else if (done_entry_s) begin
            match_r    <= (final_sig_s == golden_sig);
            mismatch_r <= (final_sig_s != golden_sig);
        end else if (start_acc_s) begin
            match_r    <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            match_r    <= match_r;
            mismatch_r <= mismatch_r;
        end
    end

    assign match    = match_r;
    assign mismatch = mismatch_r;
`else
`endif

    assign in_ready  = in_ready_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign vec_count = vec_count_r;
    assign sig_out   = sig_s;

endmodule

// File: tb/tb_aig_resp_misr.sv
// Scoreboard bench for aig_resp_misr: stimulus queues expected signatures, a monitor checks them.
// Golden-compare checks are built in when AIG_MISR_GOLDEN_CMP_EN is defined.
module tb_aig_resp_misr;
    import aig_mix_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = 16'd0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [15:0] vec_count;
    logic [63:0] sig_out;
`ifdef AIG_MISR_GOLDEN_CMP_EN
    logic [63:0] golden_sig = 64'd0;
    logic        match;
    logic        mismatch;
`endif

    typedef struct packed {
        logic [63:0] s;
        logic [15:0] c;
    } done_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] beat_q[$];
    done_t       done_q[$];
    logic        acc_q = 1'b0;
    logic        done_prev = 1'b0;

    aig_resp_misr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .sig_out   (sig_out)
`ifdef AIG_MISR_GOLDEN_CMP_EN
        ,
        .golden_sig(golden_sig),
        .match     (match),
        .mismatch  (mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        cyc();
        start   = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] exp_sig);
        in_valid = 1'b1;
        in_data  = d;
        beat_q.push_back(exp_sig);
        cyc();
        in_valid = 1'b0;
    endtask

    // Remember whether a beat was accepted on this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= 1'b0;
        else        acc_q <= in_valid && in_ready;
    end

    // Monitor: compare sig_out after every accepted beat and the final result when done rises.
    always @(negedge clk) begin : monitor
        done_t d;
        if (acc_q) begin
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: sig_out=0x%0h with no beat expected", sig_out);
            end else begin
                chk("beat_sig", sig_out, beat_q.pop_front());
            end
        end
        if (done && !done_prev) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: done rose with sig_out=0x%0h", sig_out);
            end else begin
                d = done_q.pop_front();
                chk("done_sig", sig_out, d.s);
                chk("done_count", {48'd0, vec_count}, {48'd0, d.c});
            end
        end
        done_prev <= done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_sig", sig_out, 64'd0);
        chk("rst_count", {48'd0, vec_count}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Zero length: straight to DONE, ready never raised.
        done_q.push_back('{s: 64'd0, c: 16'd0});
        start_run(16'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_ready", {63'd0, in_ready}, 64'd0);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        // Data offered outside RUN must not be consumed.
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0001;
        cyc();
        in_valid = 1'b0;
        chk("idle_data_sig", sig_out, 64'd0);
        chk("idle_data_count", {48'd0, vec_count}, 64'd0);

        // Basic run: 1, 0, 0 -> 1, 3, 7.
        done_q.push_back('{s: 64'h7, c: 16'd3});
        start_run(16'd3);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        chk("basic_ready", {63'd0, in_ready}, 64'd1);
        send(64'h1, 64'h1);
        send(64'h0, 64'h3);
        send(64'h0, 64'h7);
        chk("basic_done", {63'd0, done}, 64'd1);
        chk("basic_count", {48'd0, vec_count}, 64'd3);
        chk("basic_busy_off", {63'd0, busy}, 64'd0);

        // Bubbles: four beats 1,0,0,0 -> 1,3,7,E; state holds during idle cycles.
        done_q.push_back('{s: 64'hE, c: 16'd4});
        start_run(16'd4);
        send(64'h1, 64'h1);
        in_data = 64'hFFFF_0000_FFFF_0000;
        cyc();
        chk("bubble1_sig", sig_out, 64'h1);
        chk("bubble1_count", {48'd0, vec_count}, 64'd1);
        cyc();
        chk("bubble2_sig", sig_out, 64'h1);
        send(64'h0, 64'h3);
        cyc();
        chk("bubble3_sig", sig_out, 64'h3);
        chk("bubble3_count", {48'd0, vec_count}, 64'd2);
        send(64'h0, 64'h7);
        send(64'h0, 64'hE);
        chk("bubble_done", {63'd0, done}, 64'd1);

        // Top tap feeds back: 0x8000.. then 0 -> 0x1; start and num_vec change mid-run are ignored.
        done_q.push_back('{s: 64'h1, c: 16'd2});
        start_run(16'd2);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        start    = 1'b1;
        num_vec  = 16'd0;
        in_valid = 1'b1;
        in_data  = 64'h0;
        beat_q.push_back(64'h1);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("ign_done", {63'd0, done}, 64'd1);
        chk("ign_count", {48'd0, vec_count}, 64'd2);

        // Reset mid-run after one beat aborts to IDLE.
        start_run(16'd3);
        send(64'h1, 64'h1);
        #6;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("abort_sig", sig_out, 64'd0);
        chk("abort_count", {48'd0, vec_count}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        cyc();
        chk("abort_ready_hold", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        cyc();
        chk("abort_idle_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_idle_done", {63'd0, done}, 64'd0);

        // Basic run with a matching golden value.
`ifdef AIG_MISR_GOLDEN_CMP_EN
        golden_sig = 64'h7;
`endif
        done_q.push_back('{s: 64'h7, c: 16'd3});
        start_run(16'd3);
        send(64'h1, 64'h1);
        send(64'h0, 64'h3);
        send(64'h0, 64'h7);
`ifdef AIG_MISR_GOLDEN_CMP_EN
        chk("gold_match", {63'd0, match}, 64'd1);
        chk("gold_match_mis", {63'd0, mismatch}, 64'd0);
        golden_sig = 64'h6;
`endif
        // Same run straight out of DONE with a wrong golden value.
        done_q.push_back('{s: 64'h7, c: 16'd3});
        start_run(16'd3);
`ifdef AIG_MISR_GOLDEN_CMP_EN
        chk("gold_clear", {63'd0, match}, 64'd0);
`endif
        send(64'h1, 64'h1);
        send(64'h0, 64'h3);
        send(64'h0, 64'h7);
`ifdef AIG_MISR_GOLDEN_CMP_EN
        chk("gold_miss_match", {63'd0, match}, 64'd0);
        chk("gold_miss_mis", {63'd0, mismatch}, 64'd1);
`endif

        // Back-to-back from DONE: seed reload then all-ones.
        done_q.push_back('{s: 64'hFFFF_FFFF_FFFF_FFFF, c: 16'd1});
        start_run(16'd1);
        chk("b2b_seed", sig_out, 64'd0);
        chk("b2b_done_low", {63'd0, done}, 64'd0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_count", {48'd0, vec_count}, 64'd1);

        repeat (3) cyc();
        chk("beat_q_empty", beat_q.size(), 64'd0);
        chk("done_q_empty", done_q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
